// File: rtl/comparator_2bit.sv
// rtl/comparator_2bit.sv - registered 2-bit magnitude comparator with one-hot gt/eq/lt flags
// Build option: define COMPARATOR_SIGNED_EN to treat operands as two's complement.
module comparator_2bit (
  input  logic clk,
  input  logic rst,
  input  logic a0,
  input  logic a1,
  input  logic b0,
  input  logic b1,
  output logic out1,
  output logic out2,
  output logic out3
);

  logic gt;
  logic eq;
  logic lt;
  logic msb_a_wins;
  logic msb_b_wins;

  // In two's complement the MSB is the sign bit, so a set MSB loses the decision.
`ifdef COMPARATOR_SIGNED_EN
  assign msb_a_wins = ~a1 & b1;
  assign msb_b_wins = a1 & ~b1;
`else
  assign msb_a_wins = a1 & ~b1;
  assign msb_b_wins = ~a1 & b1;
`endif

  always_comb begin
    gt = 1'b0;
    lt = 1'b0;
    eq = (a1 ~^ b1) & (a0 ~^ b0);
    if (a1 != b1) begin
      gt = msb_a_wins;
      lt = msb_b_wins;
    end else begin
      gt = a0 & ~b0;
      lt = ~a0 & b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out1 <= 1'b0;
      out2 <= 1'b0;
      out3 <= 1'b0;
    end else begin
      out1 <= gt;
      out2 <= eq;
      out3 <= lt;
    end
  end

endmodule

// File: tb/tb_comparator_2bit.sv
// tb/tb_comparator_2bit.sv - self-checking bench for comparator_2bit (vector table, random model, reset sequences)
module tb_comparator_2bit;

  logic clk = 1'b0;
  logic rst;
  logic a0, a1, b0, b1;
  logic out1, out2, out3;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[8];

  comparator_2bit dut (
    .clk  (clk),
    .rst  (rst),
    .a0   (a0),
    .a1   (a1),
    .b0   (b0),
    .b1   (b1),
    .out1 (out1),
    .out2 (out2),
    .out3 (out3)
  );

  always #5 clk = ~clk;

  // Reference: convert to integers and compare arithmetically; result is {gt, eq, lt}.
  function automatic logic [2:0] ref_cmp(input logic [1:0] a, input logic [1:0] b);
    int sa;
    int sb;
`ifdef COMPARATOR_SIGNED_EN
    sa = (int'(a) >= 2) ? int'(a) - 4 : int'(a);
    sb = (int'(b) >= 2) ? int'(b) - 4 : int'(b);
`else
    sa = int'(a);
    sb = int'(b);
`endif
    return {sa > sb, sa == sb, sa < sb};
  endfunction

  task automatic set_ops(input logic [1:0] a, input logic [1:0] b);
    {a1, a0} = a;
    {b1, b0} = b;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] exp);
    logic [2:0] got;
    got = {out1, out2, out3};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got out1/out2/out3=%b required %b", name, got, exp);
    end
  endtask

  task automatic check_onehot(input string name);
    logic [2:0] got;
    got = {out1, out2, out3};
    checks++;
    if ($countones(got) != 1) begin
      errors++;
      $display("FAIL %s onehot: got %b required exactly one bit set", name, got);
    end
  endtask

  initial begin
    logic [1:0] ra, rb, pa, pb;
    logic [2:0] last_exp;

`ifdef COMPARATOR_SIGNED_EN
    vecs[0] = '{2'b10, 2'b01, 3'b001};
    vecs[1] = '{2'b11, 2'b10, 3'b100};
    vecs[2] = '{2'b00, 2'b11, 3'b100};
    vecs[3] = '{2'b01, 2'b10, 3'b100};
    vecs[4] = '{2'b10, 2'b10, 3'b010};
    vecs[5] = '{2'b11, 2'b00, 3'b001};
    vecs[6] = '{2'b01, 2'b00, 3'b100};
    vecs[7] = '{2'b11, 2'b11, 3'b010};
`else
    vecs[0] = '{2'd1, 2'd2, 3'b001};
    vecs[1] = '{2'd2, 2'd2, 3'b010};
    vecs[2] = '{2'd3, 2'd1, 3'b100};
    vecs[3] = '{2'b10, 2'b01, 3'b100};
    vecs[4] = '{2'b01, 2'b10, 3'b001};
    vecs[5] = '{2'd0, 2'd0, 3'b010};
    vecs[6] = '{2'd0, 2'd3, 3'b001};
    vecs[7] = '{2'd3, 2'd3, 3'b010};
`endif

    // Reset held for two edges with A=3, B=0.
    rst = 1'b1;
    set_ops(2'd3, 2'd0);
    tick;
    check("reset_edge1", 3'b000);
    tick;
    check("reset_edge2", 3'b000);
    rst = 1'b0;
    tick;
`ifdef COMPARATOR_SIGNED_EN
    check("reset_release", 3'b001);
`else
    check("reset_release", 3'b100);
`endif

    // Fixed vectors, back-to-back.
    set_ops(vecs[0].a, vecs[0].b);
    for (int i = 0; i < 8; i++) begin
      tick;
      check($sformatf("vec%0d_a%0d_b%0d", i, vecs[i].a, vecs[i].b), vecs[i].exp);
      if (i < 7) set_ops(vecs[i+1].a, vecs[i+1].b);
    end

    // Exhaustive sweep, one combination per cycle.
    set_ops(2'd0, 2'd0);
    for (int i = 0; i < 16; i++) begin
      pa = 2'(i >> 2);
      pb = 2'(i & 3);
      set_ops(pa, pb);
      tick;
      check($sformatf("sweep_a%0d_b%0d", pa, pb), ref_cmp(pa, pb));
      check_onehot("sweep");
    end

    // Input changes between edges must not reach the outputs.
    last_exp = ref_cmp(2'd3, 2'd3);
    set_ops(~pa, 2'd0);
    #3;
    check("between_edges", last_exp);

    // Random operands against the reference model.
    for (int i = 0; i < 60; i++) begin
      ra = 2'($urandom_range(0, 3));
      rb = 2'($urandom_range(0, 3));
      set_ops(ra, rb);
      tick;
      check($sformatf("rand%0d_a%0d_b%0d", i, ra, rb), ref_cmp(ra, rb));
      check_onehot("rand");
    end

    // Mid-stream reset for a single edge while operands toggle.
    pa = 2'd2;
    pb = 2'd1;
    for (int k = 0; k < 10; k++) begin
      pa = ~pa;
      pb = 2'(pb + 1);
      set_ops(pa, pb);
      rst = (k == 5);
      tick;
      if (k == 5) begin
        check("midstream_reset", 3'b000);
      end else begin
        check($sformatf("midstream%0d_a%0d_b%0d", k, pa, pb), ref_cmp(pa, pb));
        check_onehot("midstream");
      end
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
